// File: rtl/uart_pkt_tx_if.sv
// Handshake and line signals between a packet source and the UART packet transmitter.
interface uart_pkt_tx_if;
  logic        start;
  logic [7:0]  hdr;
  logic [7:0]  addr;
  logic [15:0] size;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic        tx_serial;
  logic        busy;
  logic        done;

  modport master (
    output start, hdr, addr, size, pl_data, pl_valid,
    input  pl_ready, tx_serial, busy, done
  );

  modport slave (
    input  start, hdr, addr, size, pl_data, pl_valid,
    output pl_ready, tx_serial, busy, done
  );
endinterface

// File: rtl/uart_pkt_tx.sv
// UART packet transmitter: HDR, ADDR, SIZE_LO, SIZE_HI, payload, framed as 8N1 with optional even parity.
//  state    | meaning
//  IDLE     | line high, waiting for start
//  START    | start bit (line low)
//  DATA     | 8 data bits, LSB first from shift_q[0]
//  PARITY   | even parity bit (PARITY_EN only)
//  STOP     | stop bit, all but its final cycle
//  NEXT     | final stop cycle; loads next byte, or idles high waiting for payload
module uart_pkt_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic         clock,
  input  logic         reset_n,
  uart_pkt_tx_if.slave bus
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_NEXT} state_e;
  typedef enum logic [2:0] {F_HDR, F_ADDR, F_SZ_LO, F_SZ_HI, F_PAY} field_e;

  state_e        state_q, state_d;
  field_e        field_q, field_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [15:0]   rem_q, rem_d;
  logic [7:0]    addr_q, addr_d;
  logic          baud_tick;
  logic          tx_w, ready_w, done_w;

  assign baud_tick = (baud_q == BAUD_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      field_q <= F_HDR;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      rem_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    tx_w    = 1'b1;
    ready_w = 1'b0;
    done_w  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d  = bus.addr;
          rem_d   = bus.size;
          shift_d = bus.hdr;
          par_d   = ^bus.hdr;
          field_d = F_HDR;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_w = 1'b0;
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else baud_d = baud_q + CW'(1);
      end
      S_DATA: begin
        tx_w = shift_q[0];
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            if (PARITY_EN)              state_d = S_PARITY;
            else if (CLKS_PER_BIT == 1) state_d = S_NEXT;
            else                        state_d = S_STOP;
          end
        end else baud_d = baud_q + CW'(1);
      end
      S_PARITY: begin
        tx_w = par_q;
        if (baud_tick) begin
          baud_d  = '0;
          state_d = (CLKS_PER_BIT == 1) ? S_NEXT : S_STOP;
        end else baud_d = baud_q + CW'(1);
      end
      S_STOP: begin
        if (baud_q == STOP_LAST) begin
          baud_d  = '0;
          state_d = S_NEXT;
        end else baud_d = baud_q + CW'(1);
      end
      S_NEXT: begin
        baud_d = '0;
        case (field_q)
          F_HDR: begin
            shift_d = addr_q;
            par_d   = ^addr_q;
            field_d = F_ADDR;
            state_d = S_START;
          end
          F_ADDR: begin
            shift_d = rem_q[7:0];
            par_d   = ^rem_q[7:0];
            field_d = F_SZ_LO;
            state_d = S_START;
          end
          F_SZ_LO: begin
            shift_d = rem_q[15:8];
            par_d   = ^rem_q[15:8];
            field_d = F_SZ_HI;
            state_d = S_START;
          end
          default: begin
            // rem_q doubles as the size register until the size bytes are out
            if (rem_q != 16'd0) begin
              ready_w = 1'b1;
              if (bus.pl_valid) begin
                shift_d = bus.pl_data;
                par_d   = ^bus.pl_data;
                rem_d   = rem_q - 16'd1;
                field_d = F_PAY;
                state_d = S_START;
              end
            end else begin
              done_w  = 1'b1;
              field_d = F_HDR;
              state_d = S_IDLE;
            end
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.tx_serial = tx_w;
  assign bus.pl_ready  = ready_w;
  assign bus.done      = done_w;
  assign bus.busy      = (state_q != S_IDLE) && !done_w;
endmodule
